// File: rtl/hex_disp_pkg.sv
// Shared definitions for the HEX display arbiter.
//   disp_state_e : arbiter state encoding (idle / showing an owner / blank gap)
//   SEG_BLANK    : all segments and DP off (active-low)
//   GLYPH_TABLE  : active-low g..a patterns for hex digits 0-F (b and d lower-case)
package hex_disp_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShow  = 2'd1,
    StBlank = 2'd2
  } disp_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational 7-segment decoder for one digit.
//   nibble_i : hex digit to show
//   dp_i     : 1 = decimal point lit
//   blank_i  : 1 = digit segments off (DP still follows dp_i)
//   seg_o    : active-low segments, bit7 = DP, bits6:0 = g..a
module hex7seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o[7]   = ~dp_i;
    seg_o[6:0] = blank_i ? SEG_BLANK[6:0] : GLYPH_TABLE[nibble_i];
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing HEX5..HEX0 between NUM_REQ requesters with a minimum dwell
// time per grant and an all-off gap between different owners.
//   CLOCK_50   : clock, rising edge
//   reset      : synchronous, active-high
//   req        : level request per requester
//   req_value  : requester i value at [24i+23:24i], nibble 5 -> HEX5
//   req_dp     : requester i DP mask at [6i+5:6i], 1 = lit
//   gnt        : registered one-hot grant
//   done       : one-cycle pulse to the owner in the cycle its grant ends
//   busy       : arbiter not idle
//   HEX0..HEX5 : active-low segments, bit7 = DP
// Optional: define HEX_LEADING_ZERO_BLANK_EN to blank leading zero digits (HEX0 always shown).
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned BLANK_CYCLES = 2500000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [24*NUM_REQ-1:0]  req_value,
  input  logic [6*NUM_REQ-1:0]   req_dp,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [7:0]             HEX0,
  output logic [7:0]             HEX1,
  output logic [7:0]             HEX2,
  output logic [7:0]             HEX3,
  output logic [7:0]             HEX4,
  output logic [7:0]             HEX5
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BlankLast = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  disp_state_e        st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [IdxW-1:0]    own_q, own_d;
  logic [23:0]        val_q, val_d;
  logic [5:0]         dp_q, dp_d;

  // Round-robin search starting just after the last owner.
  logic [IdxW-1:0] start_idx, cand_idx, win_idx;
  logic            win_found;

  always_comb begin
    start_idx = (own_q == LastIdx) ? '0 : own_q + IdxW'(1);
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_idx = IdxW'((32'(start_idx) + k) % NUM_REQ);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  logic [23:0] win_val, own_val;
  logic [5:0]  win_dp, own_dp;

  always_comb begin
    win_val = '0;
    win_dp  = '0;
    own_val = '0;
    own_dp  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IdxW'(k) == win_idx) begin
        win_val = req_value[24*k +: 24];
        win_dp  = req_dp[6*k +: 6];
      end
      if (IdxW'(k) == own_q) begin
        own_val = req_value[24*k +: 24];
        own_dp  = req_dp[6*k +: 6];
      end
    end
  end

  logic owner_req, others_pending, leave, arb;

  assign owner_req      = req[own_q];
  assign others_pending = |(req & ~gnt_q);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    gnt_d  = gnt_q;
    done_d = '0;
    own_d  = own_q;
    val_d  = val_q;
    dp_d   = dp_q;
    leave  = 1'b0;
    arb    = 1'b0;

    unique case (st_q)
      StIdle: arb = 1'b1;
      StShow: begin
        if (cnt_q == DwellLast) begin
          if (others_pending) begin
            leave = 1'b1;
          end else if (owner_req) begin
            // Sole requester keeps the display; refresh the frozen value.
            val_d = own_val;
            dp_d  = own_dp;
            cnt_d = '0;
          end else begin
            done_d = gnt_q;
            gnt_d  = '0;
            cnt_d  = '0;
            st_d   = StIdle;
          end
        end else if (!owner_req) begin
          leave = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StBlank: begin
        if (cnt_q == BlankLast) arb = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: st_d = StIdle;
    endcase

    if (leave) begin
      done_d = gnt_q;
      gnt_d  = '0;
      cnt_d  = '0;
      if (BLANK_CYCLES == 0) arb = 1'b1;
      else st_d = StBlank;
    end

    if (arb) begin
      cnt_d = '0;
      if (win_found) begin
        st_d  = StShow;
        gnt_d = NUM_REQ'(1) << win_idx;
        own_d = win_idx;
        val_d = win_val;
        dp_d  = win_dp;
      end else begin
        st_d = StIdle;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st_q   <= StIdle;
      cnt_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      own_q  <= LastIdx;
      val_q  <= '0;
      dp_q   <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      own_q  <= own_d;
      val_q  <= val_d;
      dp_q   <= dp_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (st_q != StIdle);

  logic [5:0] lead_blank;

`ifdef HEX_LEADING_ZERO_BLANK_EN
  logic zero_run;

  // A digit blanks only while every digit above it (and itself) is zero.
  always_comb begin
    zero_run   = 1'b1;
    lead_blank = '0;
    for (int i = 5; i >= 1; i--) begin
      zero_run      = zero_run && (val_q[4*i +: 4] == 4'h0);
      lead_blank[i] = zero_run;
    end
  end
`else
  assign lead_blank = '0;
`endif

  logic [7:0] seg [6];

  for (genvar d = 0; d < 6; d++) begin : g_dig
    hex7seg_decode u_dec (
      .nibble_i (val_q[4*d +: 4]),
      .dp_i     (dp_q[d]),
      .blank_i  (lead_blank[d]),
      .seg_o    (seg[d])
    );
  end

  logic show;
  assign show = (st_q == StShow);

  assign HEX0 = show ? seg[0] : SEG_BLANK;
  assign HEX1 = show ? seg[1] : SEG_BLANK;
  assign HEX2 = show ? seg[2] : SEG_BLANK;
  assign HEX3 = show ? seg[3] : SEG_BLANK;
  assign HEX4 = show ? seg[4] : SEG_BLANK;
  assign HEX5 = show ? seg[5] : SEG_BLANK;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter with NUM_REQ=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
module tb_hex_display_arbiter;

  localparam int NReq  = 4;
  localparam int Dwell = 8;
  localparam int Blank = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [95:0] req_value;
  logic [23:0] req_dp;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  always #5 clk = ~clk;

  hex_display_arbiter #(
    .NUM_REQ      (NReq),
    .DWELL_CYCLES (Dwell),
    .BLANK_CYCLES (Blank),
    .CNT_W        (4)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .req       (req),
    .req_value (req_value),
    .req_dp    (req_dp),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the display and how many cycles of dwell/gap remain.
  int          m_owner;       // -1 = nobody
  int          m_last;
  int          m_dwell_left;
  int          m_blank_left;
  logic [23:0] m_val;
  logic [5:0]  m_dp;
  logic [3:0]  exp_done;
  logic [6:0]  lit [16];      // active-high segment sets g..a
  logic [3:0]  rq;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_hex(input int d);
    logic [3:0] nib;
    logic       blank;
    if (m_owner < 0) return 8'hFF;
    nib   = m_val[4*d +: 4];
    blank = 1'b0;
`ifdef HEX_LEADING_ZERO_BLANK_EN
    blank = (d != 0) && ((m_val >> (4 * d)) == 24'h0);
`endif
    return {~m_dp[d], blank ? 7'h7F : ~lit[nib]};
  endfunction

  task automatic take(input int i);
    m_owner      = i;
    m_last       = i;
    m_val        = req_value[24*i +: 24];
    m_dp         = req_dp[6*i +: 6];
    m_dwell_left = Dwell;
  endtask

  task automatic try_grant();
    for (int k = 1; k <= NReq; k++) begin
      int i;
      i = (m_last + k) % NReq;
      if (req[i]) begin
        take(i);
        return;
      end
    end
  endtask

  task automatic end_grant();
    exp_done[m_owner] = 1'b1;
    m_owner           = -1;
    m_blank_left      = Blank;
  endtask

  task automatic model_step();
    exp_done = '0;
    if (reset) begin
      m_owner      = -1;
      m_last       = NReq - 1;
      m_dwell_left = 0;
      m_blank_left = 0;
    end else if (m_owner >= 0) begin
      m_dwell_left--;
      if (m_dwell_left == 0) begin
        if ((req & ~(4'b1 << m_owner)) != 4'b0) end_grant();
        else if (req[m_owner]) take(m_owner);
        else begin
          exp_done[m_owner] = 1'b1;
          m_owner           = -1;
        end
      end else if (!req[m_owner]) begin
        end_grant();
      end
    end else if (m_blank_left > 0) begin
      m_blank_left--;
      if (m_blank_left == 0) try_grant();
    end else begin
      try_grant();
    end
  endtask

  task automatic compare_all();
    chk("gnt", {4'h0, gnt}, {4'h0, (m_owner >= 0) ? (4'b1 << m_owner) : 4'b0});
    chk("done", {4'h0, done}, {4'h0, exp_done});
    chk("busy", {7'h0, busy}, {7'h0, (m_owner >= 0) || (m_blank_left > 0)});
    chk("gnt_done_excl", {4'h0, gnt & done}, 8'h00);
    chk("hex0", HEX0, exp_hex(0));
    chk("hex1", HEX1, exp_hex(1));
    chk("hex2", HEX2, exp_hex(2));
    chk("hex3", HEX3, exp_hex(3));
    chk("hex4", HEX4, exp_hex(4));
    chk("hex5", HEX5, exp_hex(5));
  endtask

  task automatic cycle(input logic r, input logic [3:0] q);
    @(negedge clk);
    reset = r;
    req   = q;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    lit = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    m_owner      = -1;
    m_last       = NReq - 1;
    m_dwell_left = 0;
    m_blank_left = 0;
    m_val        = '0;
    m_dp         = '0;
    exp_done     = '0;
    reset        = 1'b1;
    req          = '0;
    req_value    = '0;
    req_dp       = '0;

    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0000);
    chk("rst_gnt", {4'h0, gnt}, 8'h00);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    chk("rst_hex3", HEX3, 8'hFF);

    // First grant: display follows one cycle after the request.
    req_value[23:0] = 24'h123456;
    req_value[71:48] = 24'hABCDEF;
    cycle(1'b0, 4'b0001);
    chk("g1_gnt", {4'h0, gnt}, 8'h01);
    chk("g1_busy", {7'h0, busy}, 8'h01);
    chk("g1_hex5", HEX5, 8'hF9);
    chk("g1_hex4", HEX4, 8'hA4);
    chk("g1_hex3", HEX3, 8'hB0);
    chk("g1_hex2", HEX2, 8'h99);
    chk("g1_hex1", HEX1, 8'h92);
    chk("g1_hex0", HEX0, 8'h82);

    // Two requesters alternate with a blank gap between owners.
    for (int n = 0; n < 30; n++) cycle(1'b0, 4'b0101);

    // Sole requester keeps the display; mid-dwell value changes wait for re-latch.
    req_value[47:24] = 24'h0F00D1;
    for (int n = 0; n < 20; n++) begin
      if (n == 7) req_value[47:24] = 24'h00BEEF;
      cycle(1'b0, 4'b0010);
    end

    // Owner drops early, then nobody requests.
    for (int n = 0; n < 3; n++) cycle(1'b0, 4'b0100);
    for (int n = 0; n < 6; n++) cycle(1'b0, 4'b0000);
    for (int n = 0; n < 10; n++) cycle(1'b0, 4'b0100);
    for (int n = 0; n < 2; n++) cycle(1'b0, 4'b0000);
    for (int n = 0; n < 6; n++) cycle(1'b0, 4'b0000);

    // Reset in the middle of a grant.
    for (int n = 0; n < 4; n++) cycle(1'b0, 4'b0001);
    cycle(1'b1, 4'b0001);
    chk("mr_gnt", {4'h0, gnt}, 8'h00);
    chk("mr_done", {4'h0, done}, 8'h00);
    chk("mr_hex0", HEX0, 8'hFF);
    chk("mr_busy", {7'h0, busy}, 8'h00);
    cycle(1'b0, 4'b1111);
    chk("mr_regrant", {4'h0, gnt}, 8'h01);

    // Randomized traffic against the model.
    rq = 4'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(5) == 0) rq = 4'($urandom);
      if ($urandom_range(3) == 0) begin
        req_value = {$urandom, $urandom, $urandom};
        if ($urandom_range(1) == 0) req_value = req_value & {4{24'h000FFF}};
        req_dp    = 24'($urandom);
      end
      cycle($urandom_range(199) == 0, rq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
- Shares the six 7-segment displays (HEX5..HEX0) between NUM_REQ independent requesters using round-robin arbitration with a minimum dwell time.
- Each requester presents a 24-bit hex value (6 nibbles) plus decimal-point mask; the granted requester's latched value is decoded and driven to the board HEX outputs.
- Sits between lab datapaths (counters, ALUs, switch readers) and the DE10-Lite HEX pins; a short blank gap separates owners.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DWELL_CYCLES, 50000000, minimum display time per grant in CLOCK_50 cycles (1 s)
- BLANK_CYCLES, 2500000, all-segments-off gap between owners (50 ms); 0 = no gap
- CNT_W, 26, dwell/blank counter width; must hold max(DWELL_CYCLES, BLANK_CYCLES)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  request per requester, level
- req_value  in  24*NUM_REQ  requester i value at [24i+23:24i], nibble 5 -> HEX5
- req_dp  in  6*NUM_REQ  requester i DP mask at [6i+5:6i], 1 = DP lit
- gnt  out  NUM_REQ  one-hot grant, registered
- done  out  NUM_REQ  one-cycle pulse to owner when its grant ends
- busy  out  1  high when state != IDLE
- HEX0..HEX5  out  8 each  active-low segments, bit7 = DP, bits6:0 = g..a

Behaviour:
- Reset (sync, active-high): state IDLE, gnt=0, done=0, busy=0, all HEX=8'hFF, rr pointer=0, counters=0. Reset mid-grant drops everything at that edge; no done pulse.
- States: IDLE, SHOW, BLANK.
- Arbitration: search starts at index (last_owner+1) mod NUM_REQ, wraps, first req=1 wins. After reset, last_owner = NUM_REQ-1, so req[0] has priority.
- IDLE: if any req at edge k -> SHOW after edge k; gnt one-hot set, value/dp latched, HEX driven from latched value in the same cycle gnt rises (1-cycle latency req->display). No blank from IDLE.
- SHOW: dwell counter counts 0..DWELL_CYCLES-1.
  - Owner drops req before expiry: pulse done, gnt=0, go BLANK (or arbitrate directly if BLANK_CYCLES=0).
  - At expiry with another requester pending: pulse done, gnt=0, go BLANK.
  - At expiry with only the owner requesting: keep gnt, re-latch value/dp, restart dwell; no done pulse.
  - At expiry with nobody requesting: pulse done, go IDLE.
- The latched value is frozen for the whole dwell; req_value changes mid-dwell are not shown until re-latch.
- BLANK: HEX=8'hFF for exactly BLANK_CYCLES cycles; then arbitrate as in IDLE. If no req is present, go IDLE.
- done is asserted in the same cycle gnt deasserts; done and gnt are never both high for one index.
- Decode: 0-F standard hex glyphs (b and d lower-case), active-low; DP bit = ~dp.

Optional Feature:
- HEX_LEADING_ZERO_BLANK_EN defined: leading zero nibbles from HEX5 downward blank to 8'hFF, but their DP still shows; HEX0 always shows its digit. Example: 24'h000A30 shows blank,blank,blank,A,3,0.
- Not defined: all six digits are always decoded.

Decomposition:
- Package hex_disp_pkg: state encoding (IDLE=2'd0, SHOW=2'd1, BLANK=2'd2), SEG_BLANK=8'hFF, 16-entry glyph constant table.
- One sub-module, hex7seg_decode: combinational; 4-bit nibble + dp + blank -> 8-bit active-low segments. Instantiated six times.

Test Plan (DWELL_CYCLES=8, BLANK_CYCLES=2, NUM_REQ=4):
- Reset then req=4'b0001, value0=24'h123456 -> next cycle gnt=0001, HEX5..HEX0 = 8'hF9,A4,B0,99,92,82; busy=1.
- req=4'b0101 held -> gnt 0001 for 8 cycles, done[0] pulse, 2 cycles of all HEX=FF, then gnt=0100; then back to 0001 (round-robin).
- Only req[1] held for 20 cycles -> gnt stays 0010 continuously; value change at cycle 3 appears only at cycle 8 re-latch; no done pulse.
- Owner req[2] drops at cycle 3 of dwell -> done[2] pulses next edge, gnt=0, blank 2 cycles, IDLE if no req.
- reset asserted mid-SHOW -> next cycle gnt=0, done=0, all HEX=FF, state IDLE; then req=1111 -> grant to index 0.
- With HEX_LEADING_ZERO_BLANK_EN, value 24'h000A30, dp=6'b100000 -> HEX5=8'h7F, HEX4..HEX3=FF, HEX2=88, HEX1=B0, HEX0=C0.
